// File: rtl/seg_scan_ctrl_if.sv
// Bundle of display-source and pin-side signals for the seven-segment scanner.
// The master modport belongs to the debug data mux, the slave modport to the scanner.
interface seg_scan_ctrl_if #(
  parameter int N_DIGITS = 8,
  parameter int BRIGHT_W = 3
);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [4*N_DIGITS-1:0] data_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   blank_in;
  logic                  load;
  logic                  lz_en;
  logic [BRIGHT_W-1:0]   brightness;
  logic [6:0]            seg;
  logic                  dp;
  logic [N_DIGITS-1:0]   an;
  logic [IDX_W-1:0]      digit_idx;
  logic                  frame_done;

  modport master (
    output data_in, dp_in, blank_in, load, lz_en, brightness,
    input  seg, dp, an, digit_idx, frame_done
  );

  modport slave (
    input  data_in, dp_in, blank_in, load, lz_en, brightness,
    output seg, dp, an, digit_idx, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// N-digit multiplexed seven-segment scanner with frame-aligned double buffering,
// leading-zero suppression, PWM brightness, anti-ghost blanking and pin polarity.
module seg_scan_ctrl #(
  parameter int N_DIGITS   = 8,
  parameter int TICK_LOG2  = 15,
  parameter int BRIGHT_W   = 3,
  parameter int BLANK_CYC  = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic           clk,
  input  logic           reset,
  seg_scan_ctrl_if.slave bus
);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(N_DIGITS - 1);
  localparam logic [TICK_LOG2-1:0] BLANK_THR = TICK_LOG2'(BLANK_CYC);
  localparam logic                 POL       = (ACTIVE_LOW != 0);
  localparam logic [6:0]           SEG_POL   = {7{POL}};
  localparam logic [N_DIGITS-1:0]  AN_POL    = {N_DIGITS{POL}};
  localparam logic [N_DIGITS-1:0]  AN_ONE    = {{(N_DIGITS-1){1'b0}}, 1'b1};

  // Scan timing
  logic [TICK_LOG2-1:0]  tick_cnt_reg;
  logic [IDX_W-1:0]      idx_reg;

  // Pending buffer written by load, shadow buffer drives the display
  logic [4*N_DIGITS-1:0] pend_data_reg;
  logic [N_DIGITS-1:0]   pend_dp_reg;
  logic [N_DIGITS-1:0]   pend_blank_reg;
  logic                  pend_valid_reg;
  logic [4*N_DIGITS-1:0] shad_data_reg;
  logic [N_DIGITS-1:0]   shad_dp_reg;
  logic [N_DIGITS-1:0]   shad_blank_reg;

  // Pin registers
  logic [6:0]            seg_reg;
  logic                  dp_reg;
  logic [N_DIGITS-1:0]   an_reg;
  logic [IDX_W-1:0]      digit_idx_reg;
  logic                  frame_done_reg;

  logic                  slot_end;
  logic                  frame_end;
  logic [3:0]            shad_nib [N_DIGITS];
  logic [N_DIGITS-1:0]   dark;
  logic                  lit_win;
  logic                  digit_dark;
  logic [6:0]            seg_next;
  logic                  dp_next;
  logic [N_DIGITS-1:0]   an_next;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign slot_end  = &tick_cnt_reg;
  assign frame_end = slot_end && (idx_reg == LAST_IDX);

  // A digit is a leading zero when it and every more significant nibble are zero;
  // digit 0 always stays visible so an all-zero value still shows "0".
  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      assign shad_nib[gi] = shad_data_reg[4*gi +: 4];
      if (gi == 0) begin : g_lsd
        assign dark[gi] = shad_blank_reg[gi];
      end else begin : g_upper
        assign dark[gi] = shad_blank_reg[gi] |
                          (bus.lz_en & ~|shad_data_reg[4*N_DIGITS-1 : 4*gi]);
      end
    end
  endgenerate

  always_comb begin
    lit_win    = (tick_cnt_reg >= BLANK_THR) &&
                 (tick_cnt_reg[TICK_LOG2-1 -: BRIGHT_W] <= bus.brightness);
    digit_dark = dark[idx_reg];
    seg_next   = digit_dark ? 7'h00 : hex_to_seg(shad_nib[idx_reg]);
    dp_next    = !digit_dark && shad_dp_reg[idx_reg];
    an_next    = (!digit_dark && lit_win) ? (AN_ONE << idx_reg) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_reg   <= '0;
      idx_reg        <= '0;
      pend_data_reg  <= '0;
      pend_dp_reg    <= '0;
      pend_blank_reg <= '0;
      pend_valid_reg <= 1'b0;
      shad_data_reg  <= '0;
      shad_dp_reg    <= '0;
      shad_blank_reg <= '0;
      seg_reg        <= SEG_POL;
      dp_reg         <= POL;
      an_reg         <= AN_POL;
      digit_idx_reg  <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 1'b1;
      if (slot_end) begin
        idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
      end

      // Shadow only changes at the frame boundary; a load landing on that exact
      // cycle bypasses the pending buffer.
      if (frame_end && bus.load) begin
        shad_data_reg  <= bus.data_in;
        shad_dp_reg    <= bus.dp_in;
        shad_blank_reg <= bus.blank_in;
        pend_valid_reg <= 1'b0;
      end else if (frame_end && pend_valid_reg) begin
        shad_data_reg  <= pend_data_reg;
        shad_dp_reg    <= pend_dp_reg;
        shad_blank_reg <= pend_blank_reg;
        pend_valid_reg <= 1'b0;
      end else if (bus.load) begin
        pend_data_reg  <= bus.data_in;
        pend_dp_reg    <= bus.dp_in;
        pend_blank_reg <= bus.blank_in;
        pend_valid_reg <= 1'b1;
      end

      seg_reg        <= seg_next ^ SEG_POL;
      dp_reg         <= dp_next ^ POL;
      an_reg         <= an_next ^ AN_POL;
      digit_idx_reg  <= idx_reg;
      frame_done_reg <= frame_end;
    end
  end

  assign bus.seg        = seg_reg;
  assign bus.dp         = dp_reg;
  assign bus.an         = an_reg;
  assign bus.digit_idx  = digit_idx_reg;
  assign bus.frame_done = frame_done_reg;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Frame-level scoreboard bench for seg_scan_ctrl: one expected frame image is queued
// per scanned frame and compared against the pins collected up to frame_done.
module tb_seg_scan_ctrl;
  localparam int N  = 4;
  localparam int TL = 4;
  localparam int BW = 2;
  localparam int BC = 1;
  localparam int AL = 1;
  localparam int NO = -1;

  typedef struct packed {
    logic [3:0][6:0]  seg;
    logic [3:0]       dp;
    logic [3:0][15:0] mask;
  } frame_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rst_d = 1'b1;
  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.N_DIGITS(N), .BRIGHT_W(BW)) bus ();

  seg_scan_ctrl #(
    .N_DIGITS(N), .TICK_LOG2(TL), .BRIGHT_W(BW), .BLANK_CYC(BC), .ACTIVE_LOW(AL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int     checks      = 0;
  int     failures    = 0;
  int     frames_seen = 0;
  frame_t exp_q[$];

  // Reference model of the double buffer
  logic [15:0] m_shad_d, m_pend_d;
  logic [3:0]  m_shad_dp, m_shad_bl, m_pend_dp, m_pend_bl;
  logic        m_pend_v;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic frame_t build_exp(input logic [15:0] d, input logic [3:0] dpv,
                                       input logic [3:0] blv, input logic lz,
                                       input logic [1:0] br);
    logic [6:0] tbl [16];
    frame_t     f;
    logic       dark;
    logic [3:0] nib;
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    f = '0;
    for (int k = 0; k < 4; k++) begin
      nib  = d[4*k +: 4];
      dark = blv[k] || (lz && k != 0 && (d >> (4*k)) == 16'h0);
      f.seg[k] = dark ? 7'h7F : ~tbl[nib];
      f.dp[k]  = dark ? 1'b1 : ~dpv[k];
      for (int t = 0; t < 16; t++) begin
        if (!dark && t >= BC && (t >> 2) <= int'(br)) f.mask[k][t] = 1'b1;
      end
    end
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_shad_d = '0; m_shad_dp = '0; m_shad_bl = '0;
    m_pend_d = '0; m_pend_dp = '0; m_pend_bl = '0;
    m_pend_v = 1'b0;
  endtask

  // Drive one frame (64 cycles, starting in the cycle with tick=0, idx=0) with up to
  // two loads at cycle offsets lc0/lc1; offset 63 is the frame_end cycle.
  task automatic run_frame(input int lc0, input logic [15:0] d0, input logic [3:0] p0,
                           input logic [3:0] b0, input int lc1, input logic [15:0] d1,
                           input logic [3:0] p1, input logic [3:0] b1);
    exp_q.push_back(build_exp(m_shad_d, m_shad_dp, m_shad_bl, bus.lz_en, bus.brightness));
    for (int c = 0; c < 64; c++) begin
      if (c == lc0 || c == lc1) begin
        bus.load     = 1'b1;
        bus.data_in  = (c == lc0) ? d0 : d1;
        bus.dp_in    = (c == lc0) ? p0 : p1;
        bus.blank_in = (c == lc0) ? b0 : b1;
        if (c == 63) begin
          m_shad_d = bus.data_in; m_shad_dp = bus.dp_in; m_shad_bl = bus.blank_in;
          m_pend_v = 1'b0;
        end else begin
          m_pend_d = bus.data_in; m_pend_dp = bus.dp_in; m_pend_bl = bus.blank_in;
          m_pend_v = 1'b1;
        end
      end else begin
        bus.load     = 1'b0;
        bus.data_in  = 16'($urandom);
        bus.dp_in    = 4'($urandom);
        bus.blank_in = 4'($urandom);
        if (c == 63 && m_pend_v) begin
          m_shad_d = m_pend_d; m_shad_dp = m_pend_dp; m_shad_bl = m_pend_bl;
          m_pend_v = 1'b0;
        end
      end
      tick();
    end
    bus.load = 1'b0;
  endtask

  // Pins lag the scan state by one cycle, so pins sampled after a reset edge are skipped.
  always @(posedge clk) rst_d <= reset;

  logic [3:0][6:0]  seg_obs;
  logic [3:0]       dp_obs;
  logic [3:0][15:0] mask_obs;
  int               pos [4];
  int               cyc_cnt;
  int               bad_cnt;
  int               di;
  logic [3:0]       an_exp;
  frame_t           e;

  always @(negedge clk) begin
    if (rst_d) begin
      seg_obs = '0; dp_obs = '0; mask_obs = '0;
      for (int k = 0; k < 4; k++) pos[k] = 0;
      cyc_cnt = 0; bad_cnt = 0;
    end else begin
      cyc_cnt++;
      di = int'(bus.digit_idx);
      seg_obs[di] = bus.seg;
      dp_obs[di]  = bus.dp;
      if (bus.an != 4'hF) begin
        an_exp = ~(4'b0001 << di);
        if (bus.an == an_exp && pos[di] < 16) mask_obs[di][pos[di]] = 1'b1;
        else bad_cnt++;
      end
      pos[di]++;
      if (bus.frame_done) begin
        frames_seen++;
        check_eq("frame_len", cyc_cnt, 64);
        check_eq("an_legal", bad_cnt, 0);
        check_eq("sb_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("seg_d%0d", k), seg_obs[k], e.seg[k]);
            check_eq($sformatf("dp_d%0d", k), dp_obs[k], e.dp[k]);
            check_eq($sformatf("an_mask_d%0d", k), mask_obs[k], e.mask[k]);
          end
        end
        $display("frame %0d: seg=%h_%h_%h_%h dp=%b lit=%h_%h_%h_%h", frames_seen,
                 seg_obs[3], seg_obs[2], seg_obs[1], seg_obs[0], dp_obs,
                 mask_obs[3], mask_obs[2], mask_obs[1], mask_obs[0]);
        seg_obs = '0; dp_obs = '0; mask_obs = '0;
        for (int k = 0; k < 4; k++) pos[k] = 0;
        cyc_cnt = 0; bad_cnt = 0;
      end
    end
  end

  initial begin
    bus.load = 1'b0; bus.data_in = '0; bus.dp_in = '0; bus.blank_in = '0;
    bus.lz_en = 1'b1; bus.brightness = 2'd3;
    reset = 1'b1;
    model_clear();
    repeat (3) tick();
    check_eq("rst_an", bus.an, 4'hF);
    check_eq("rst_seg", bus.seg, 7'h7F);
    check_eq("rst_dp", bus.dp, 1'b1);
    check_eq("rst_frame_done", bus.frame_done, 1'b0);
    check_eq("rst_idx", bus.digit_idx, 2'd0);
    reset = 1'b0;

    run_frame(NO, 16'h0, 4'h0, 4'h0, NO, 16'h0, 4'h0, 4'h0);
    bus.lz_en = 1'b0;
    run_frame(10, 16'h12AF, 4'b0011, 4'h0, NO, 16'h0, 4'h0, 4'h0);
    run_frame(NO, 16'h0, 4'h0, 4'h0, NO, 16'h0, 4'h0, 4'h0);
    run_frame(30, 16'h3456, 4'h0, 4'h0, 50, 16'h789B, 4'b1010, 4'h0);
    run_frame(63, 16'hC0DE, 4'h0, 4'h0, NO, 16'h0, 4'h0, 4'h0);
    run_frame(5, 16'h1111, 4'h0, 4'h0, 63, 16'hE0E0, 4'b0001, 4'h0);
    bus.lz_en = 1'b1;
    run_frame(10, 16'h0050, 4'h0, 4'h0, NO, 16'h0, 4'h0, 4'h0);
    run_frame(NO, 16'h0, 4'h0, 4'h0, NO, 16'h0, 4'h0, 4'h0);
    bus.brightness = 2'd0;
    run_frame(0, 16'h0000, 4'h0, 4'h0, NO, 16'h0, 4'h0, 4'h0);
    bus.brightness = 2'd1;
    run_frame(2, 16'h8888, 4'b0100, 4'b0100, NO, 16'h0, 4'h0, 4'h0);
    bus.brightness = 2'd0;
    run_frame(NO, 16'h0, 4'h0, 4'h0, NO, 16'h0, 4'h0, 4'h0);

    // Mid-frame reset with a pending load outstanding
    bus.brightness = 2'd3;
    bus.lz_en = 1'b0;
    for (int c = 0; c < 20; c++) begin
      bus.load = (c == 5);
      bus.data_in = 16'h9999;
      tick();
    end
    bus.load = 1'b0;
    reset = 1'b1;
    tick();
    check_eq("mid_rst_an", bus.an, 4'hF);
    check_eq("mid_rst_seg", bus.seg, 7'h7F);
    check_eq("mid_rst_dp", bus.dp, 1'b1);
    check_eq("mid_rst_idx", bus.digit_idx, 2'd0);
    check_eq("mid_rst_frame_done", bus.frame_done, 1'b0);
    reset = 1'b0;
    model_clear();
    run_frame(NO, 16'h0, 4'h0, 4'h0, NO, 16'h0, 4'h0, 4'h0);
    run_frame(NO, 16'h0, 4'h0, 4'h0, NO, 16'h0, 4'h0, 4'h0);

    @(negedge clk);
    #1;
    check_eq("sb_drain", exp_q.size(), 0);
    check_eq("frames_seen", frames_seen, 13);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
